// File: rtl/pc_sequencer_if.sv
// Request/response bundle between fetch/execute control and the PC sequencer.
// The sequencer side is the slave modport; dbg_state mirrors the internal FSM.
interface pc_sequencer_if #(
  parameter int AW = 32
) ();
  // Level-sampled controls: the sequencer samples every request input on each rising
  // clk edge; there is no ready back-pressure, and stall is the only hold mechanism.
  logic          stall;
  logic          redir_valid;
  logic [AW-1:0] redir_addr;
  logic          exc_req;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_plus_step;
  logic          pc_valid;
  logic          fault;
  logic [AW-1:0] fault_addr;
  logic [1:0]    dbg_state;

  modport master (
    output stall, redir_valid, redir_addr, exc_req,
    input  pc, pc_plus_step, pc_valid, fault, fault_addr, dbg_state
  );

  modport slave (
    input  stall, redir_valid, redir_addr, exc_req,
    output pc, pc_plus_step, pc_valid, fault, fault_addr, dbg_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential step with wrap, redirect, exception vectoring, stall.
// Define PC_DELAY_SLOT_EN to defer legal redirects behind one branch delay slot.
module pc_sequencer #(
  parameter int unsigned    AW         = 32,
  parameter int unsigned    STEP       = 4,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  parameter int unsigned    WRAP_LIMIT = 1024,
  parameter logic [AW-1:0]  EXC_VECTOR = 'h380
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_e;

  localparam logic [AW:0]   LIMIT_W    = (AW+1)'(WRAP_LIMIT);
  localparam logic [AW:0]   STEP_W     = (AW+1)'(STEP);
  localparam logic [AW-1:0] ALIGN_MASK = AW'(STEP - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pc_valid_q, pc_valid_d;
  logic          fault_q, fault_d;
  logic [AW-1:0] fault_addr_q, fault_addr_d;

  logic [AW:0]   seq_sum;
  logic [AW-1:0] seq_pc;
  logic          redir_illegal;
  logic          redir_take;

`ifdef PC_DELAY_SLOT_EN
  logic          pend_valid_q, pend_valid_d;
  logic          pend_slot_q, pend_slot_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  assign redir_take = bus.redir_valid && !pend_valid_q;
`else
  assign redir_take = bus.redir_valid;
`endif

  // The extra sum bit makes a carry-out count as reaching the limit.
  assign seq_sum       = {1'b0, pc_q} + STEP_W;
  assign seq_pc        = (seq_sum >= LIMIT_W) ? RESET_ADDR : seq_sum[AW-1:0];
  assign redir_illegal = ({1'b0, bus.redir_addr} >= LIMIT_W) ||
                         ((bus.redir_addr & ALIGN_MASK) != '0);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
`ifdef PC_DELAY_SLOT_EN
    pend_valid_d = pend_valid_q;
    pend_slot_d  = pend_slot_q;
    pend_addr_d  = pend_addr_q;
`endif
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (bus.exc_req) begin
          pc_d = EXC_VECTOR;
`ifdef PC_DELAY_SLOT_EN
          pend_valid_d = 1'b0;
          pend_slot_d  = 1'b0;
`endif
        end else if (redir_take && redir_illegal) begin
          fault_addr_d = bus.redir_addr;
          state_d      = ST_FAULT;
`ifdef PC_DELAY_SLOT_EN
          pend_valid_d = 1'b0;
          pend_slot_d  = 1'b0;
`endif
        end else if (redir_take) begin
`ifdef PC_DELAY_SLOT_EN
          // The capture edge doubles as the delay-slot fetch unless stalled.
          pend_valid_d = 1'b1;
          pend_addr_d  = bus.redir_addr;
          pend_slot_d  = bus.stall;
          if (!bus.stall) pc_d = seq_pc;
`else
          pc_d = bus.redir_addr;
`endif
        end else if (!bus.stall) begin
`ifdef PC_DELAY_SLOT_EN
          if (pend_valid_q && !pend_slot_q) begin
            pc_d         = pend_addr_q;
            pend_valid_d = 1'b0;
          end else begin
            pc_d        = seq_pc;
            pend_slot_d = 1'b0;
          end
`else
          pc_d = seq_pc;
`endif
        end
      end
      ST_FAULT: begin
        if (bus.exc_req) begin
          pc_d    = EXC_VECTOR;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN);
    fault_d    = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDR;
      pc_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
`ifdef PC_DELAY_SLOT_EN
      pend_valid_q <= 1'b0;
      pend_slot_q  <= 1'b0;
      pend_addr_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_valid_q   <= pc_valid_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
`ifdef PC_DELAY_SLOT_EN
      pend_valid_q <= pend_valid_d;
      pend_slot_q  <= pend_slot_d;
      pend_addr_q  <= pend_addr_d;
`endif
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_step = pc_q + AW'(STEP);
  assign bus.pc_valid     = pc_valid_q;
  assign bus.fault        = fault_q;
  assign bus.fault_addr   = fault_addr_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters (AW=32, STEP=4, limit 1024).
module tb_pc_sequencer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_sequencer_if #(.AW(32)) bus ();

  pc_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [31:0] ra, input logic ex);
    bus.stall       = st;
    bus.redir_valid = rv;
    bus.redir_addr  = ra;
    bus.exc_req     = ex;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_valid", {31'b0, bus.pc_valid}, 32'h0);
    chk("rst_fault", {31'b0, bus.fault}, 32'h0);
    chk("rst_fault_addr", bus.fault_addr, 32'h0);
    chk("rst_state", {30'b0, bus.dbg_state}, 32'h0);

    // BOOT cycle: stall must be ignored
    reset = 1'b0;
    bus.stall = 1'b1;
    step();
    chk("boot_pc", bus.pc, 32'h0);
    chk("boot_valid", {31'b0, bus.pc_valid}, 32'h1);
    chk("boot_pps", bus.pc_plus_step, 32'h4);
    bus.stall = 1'b0;
    step();
    chk("seq_pc4", bus.pc, 32'h4);
    step();
    chk("seq_pc8", bus.pc, 32'h8);

    repeat (253) step();
    chk("pre_wrap_pc", bus.pc, 32'd1020);
    chk("pre_wrap_pps", bus.pc_plus_step, 32'd1024);
    step();
    chk("wrap_pc", bus.pc, 32'h0);
    repeat (4) step();
    chk("pc16", bus.pc, 32'd16);

    bus.stall = 1'b1;
    repeat (3) step();
    chk("stall_pc", bus.pc, 32'd16);
    chk("stall_valid", {31'b0, bus.pc_valid}, 32'h1);

`ifndef PC_DELAY_SLOT_EN
    drive(1'b1, 1'b1, 32'h40, 1'b0);
    step();
    chk("redir_stall_pc", bus.pc, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("post_redir_pc", bus.pc, 32'h44);
    drive(1'b0, 1'b1, 32'h3fc, 1'b0);
    step();
    chk("redir_edge_pc", bus.pc, 32'h3fc);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    chk("redir40_pc", bus.pc, 32'h40);
`else
    bus.stall = 1'b0;
    step();
    chk("ds_seq20", bus.pc, 32'd20);
    // branch at 20 -> slot 24 -> target 0x40
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    chk("ds_slot", bus.pc, 32'd24);
    drive(1'b0, 1'b1, 32'h80, 1'b0);
    step();
    chk("ds_target", bus.pc, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("ds_after", bus.pc, 32'h44);
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    step();
    chk("ds_slot2", bus.pc, 32'h48);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("ds_slot_stall", bus.pc, 32'h48);
    bus.stall = 1'b0;
    step();
    chk("ds_target2", bus.pc, 32'h200);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    step();
    chk("ds_slot3", bus.pc, 32'h204);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("redir40_pc", bus.pc, 32'h40);
`endif

    // illegal (misaligned) redirect -> FAULT
    drive(1'b0, 1'b1, 32'h42, 1'b0);
    step();
    chk("flt_fault", {31'b0, bus.fault}, 32'h1);
    chk("flt_addr", bus.fault_addr, 32'h42);
    chk("flt_valid", {31'b0, bus.pc_valid}, 32'h0);
    chk("flt_pc", bus.pc, 32'h40);
    chk("flt_state", {30'b0, bus.dbg_state}, 32'h2);
    drive(1'b1, 1'b1, 32'h80, 1'b0);
    step();
    chk("flt_hold_pc", bus.pc, 32'h40);
    chk("flt_hold_addr", bus.fault_addr, 32'h42);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    step();
    chk("exc_pc", bus.pc, 32'h380);
    chk("exc_fault", {31'b0, bus.fault}, 32'h0);
    chk("exc_valid", {31'b0, bus.pc_valid}, 32'h1);
    chk("exc_keep_addr", bus.fault_addr, 32'h42);

    // exception outranks a redirect and a stall in the same cycle
    drive(1'b1, 1'b1, 32'h100, 1'b1);
    step();
    chk("exc_vs_redir", bus.pc, 32'h380);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("exc_seq", bus.pc, 32'h384);

    // out-of-range redirect, then reset in FAULT
    drive(1'b0, 1'b1, 32'h400, 1'b0);
    step();
    chk("range_fault", {31'b0, bus.fault}, 32'h1);
    chk("range_addr", bus.fault_addr, 32'h400);
    chk("range_pc", bus.pc, 32'h384);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    reset = 1'b1;
    step();
    chk("rst2_pc", bus.pc, 32'h0);
    chk("rst2_fault", {31'b0, bus.fault}, 32'h0);
    chk("rst2_fault_addr", bus.fault_addr, 32'h0);
    chk("rst2_valid", {31'b0, bus.pc_valid}, 32'h0);
    reset = 1'b0;
    step();
    step();
    chk("rst2_run_pc", bus.pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
